tmcu_gpio_irq: RTL
==================

// Module: tmcu_gpio_irq
// PURPOSE
// - Input-side companion to the GPIO block: consumes the shared gpio pin bus and turns it into
//   synchronized pin state plus per-pin interrupts, under its own APB slot.
// - Pin-change events (edge or level, selectable polarity) latch into a W1C status register.
// - The enabled-and-pending OR drives a single irq line to the core interrupt input.
// PARAMETERS
// - NPINS        32  number of GPIO pins monitored (1..32)
// - SYNC_STAGES  2   metastability synchronizer depth (>=2)
// - DB_CYCLES    16  debounce stable-cycle count (used only with GPIO_DEBOUNCE_EN)
// PORTS
// - clk      in   1      system clock; all logic on posedge
// - rst      in   1      synchronous, active-high reset
// - psel     in   1      APB select
// - penable  in   1      APB enable (access phase)
// - pwrite   in   1      APB write (1) / read (0)
// - paddr    in   8      APB byte address; decode paddr[4:0]
// - pwdata   in   32     APB write data
// - prdata   out  32     APB read data, registered
// - pready   out  1      APB ready, registered one-cycle pulse
// - gpio_in  in   NPINS  asynchronous pin levels (the GPIO pin bus)
// - irq      out  1      level interrupt request
// BEHAVIOUR
// - Reset (synchronous, active-high): all registers, sync/debounce state, prdata, pready, irq <= 0.
// - Sync: gpio_in passes SYNC_STAGES flops to give pin_s.
//   - Edge/level detection compares pin_s against pin_q (previous pin_s).
//   - Detection is suppressed until SYNC_STAGES+1 cycles after rst deasserts, so no spurious
//     edges occur at startup or after reset mid-operation.
// - Register map (bits >= NPINS read 0, ignore writes):
//   - 0x00 IN      RO   pin_s (post-debounce when the feature is compiled in)
//   - 0x04 EN      RW   per-pin interrupt enable
//   - 0x08 TYPE    RW   1 = edge, 0 = level
//   - 0x0C POL     RW   edge: 1 = rising / 0 = falling; level: 1 = high / 0 = low
//   - 0x10 BOTH    RW   1 = any edge; overrides POL when TYPE = 1
//   - 0x14 STATUS  W1C  pending events; reads return the current value
//   - other addresses: read 0, writes ignored, still complete with pready
// - APB handshake:
//   - An access cycle is psel && penable && !pready.
//   - In that cycle the write is committed and prdata is loaded.
//   - pready = 1 on the next cycle only. Back-to-back accesses therefore take 2 cycles each.
//   - prdata holds its value between reads.
// - Status set, per pin i, only when EN[i] = 1:
//   - edge: the selected transition on pin_s vs pin_q
//   - level: set every cycle the level is active; a W1C clear re-sets next cycle if still active
// - Status set and W1C of the same bit in the same cycle: set wins.
// - Clearing EN[i] does not clear STATUS[i]; it only masks the bit from irq.
// - irq is registered: irq <= |(STATUS & EN). Latency from pin transition to irq is
//   SYNC_STAGES+2 clocks without debounce.
// - Writing TYPE/POL/BOTH does not itself create an event.
// CONFIGURATION
// - GPIO_DEBOUNCE_EN defined:
//   - Per-pin counter of width $clog2(DB_CYCLES+1) placed after the synchronizer.
//   - The filtered value updates only after the raw synced value differs from it for DB_CYCLES
//     consecutive clocks; any mismatch gap restarts the count.
//   - All detection, and the IN register, use the filtered value.
//   - Adds DB_CYCLES clocks of latency.
// - GPIO_DEBOUNCE_EN undefined: no counters; pin_s is used directly; DB_CYCLES is ignored.
// TESTING
// - Reset: hold rst with gpio_in=32'hFFFF_FFFF, release -> STATUS reads 0, irq=0, IN=32'hFFFF_FFFF
//   after SYNC_STAGES+1 clk.
// - Rising edge: EN=1, TYPE=1, POL=1; pin0 0->1 -> STATUS=0x1 and irq=1 within SYNC_STAGES+2 clk;
//   write STATUS=0x1 -> STATUS=0, irq=0 next cycle.
// - Level: pin3 held low, TYPE[3]=0, POL[3]=0, EN=0x8 -> W1C 0x8 then read -> still 0x8;
//   drive pin3 high, W1C -> reads 0.
// - Both edges: BOTH[5]=1, EN[5]=1; pulse pin5 0->1->0 with a W1C between -> STATUS[5] sets twice.
//   EN=0 -> irq=0 while STATUS stays set.
// - Collision: W1C of bit 2 in the same cycle pin2's edge is detected -> STATUS[2] remains 1.
//   Read 0x1C -> prdata=0, pready pulse of exactly 1 cycle.
// - Debounce (GPIO_DEBOUNCE_EN, DB_CYCLES=16): glitch pin1 high for 10 clk -> no event, IN[1]=0;
//   hold high 16+ clk -> IN[1]=1 and edge flagged.

Source files
------------

// File: rtl/tmcu_gpio_irq.sv
// GPIO input monitor: pin synchronizer, per-pin edge/level event capture into a W1C
// status register, and a registered interrupt line. Optional filter: GPIO_DEBOUNCE_EN.
module tmcu_gpio_irq #(
  parameter int NPINS       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [7:0]       paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  input  logic [NPINS-1:0] gpio_in,
  output logic             irq
);

  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int ARM_W = $clog2(ARM_N + 1);

  localparam logic [4:0] A_IN     = 5'h00;
  localparam logic [4:0] A_EN     = 5'h04;
  localparam logic [4:0] A_TYPE   = 5'h08;
  localparam logic [4:0] A_POL    = 5'h0C;
  localparam logic [4:0] A_BOTH   = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h14;

  logic [NPINS-1:0] sync_q [SYNC_STAGES];
  logic [NPINS-1:0] sync_d [SYNC_STAGES];
  logic [NPINS-1:0] pin_raw;
  logic [NPINS-1:0] pin_v;
  logic [NPINS-1:0] pin_q, pin_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed;

  logic [NPINS-1:0] en_q, en_d;
  logic [NPINS-1:0] type_q, type_d;
  logic [NPINS-1:0] pol_q, pol_d;
  logic [NPINS-1:0] both_q, both_d;
  logic [NPINS-1:0] status_q, status_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             pready_q, pready_d;
  logic             irq_q, irq_d;

  logic             access;
  logic [NPINS-1:0] w1c;
  logic [NPINS-1:0] rise, fall, edge_evt, level_evt, evt;
  logic [31:0]      rdata;
  logic             unused_ok;

  assign unused_ok = ^{paddr[7:5], pwdata, DB_CYCLES};

  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign pin_raw = sync_q[SYNC_STAGES-1];

  // Detection stays off until the synchronizer has flushed post-reset zeros.
  assign armed = (arm_cnt_q == ARM_W'(ARM_N));

  always_comb begin
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);

  logic [DB_W-1:0]  db_cnt_q [NPINS];
  logic [DB_W-1:0]  db_cnt_d [NPINS];
  logic [NPINS-1:0] filt_q, filt_d;

  // Before arming the filter tracks the raw value so startup never looks like a change.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NPINS; i++) begin
      db_cnt_d[i] = '0;
      if (!armed) begin
        filt_d[i] = pin_raw[i];
      end else if (pin_raw[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          filt_d[i] = pin_raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < NPINS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign pin_v = filt_q;
  assign pin_d = armed ? filt_q : pin_raw;
`else
  assign pin_v = pin_raw;
  assign pin_d = pin_raw;
`endif

  assign access = psel && penable && !pready_q;

  always_comb begin
    en_d   = en_q;
    type_d = type_q;
    pol_d  = pol_q;
    both_d = both_q;
    w1c    = '0;
    if (access && pwrite) begin
      case (paddr[4:0])
        A_EN:     en_d   = pwdata[NPINS-1:0];
        A_TYPE:   type_d = pwdata[NPINS-1:0];
        A_POL:    pol_d  = pwdata[NPINS-1:0];
        A_BOTH:   both_d = pwdata[NPINS-1:0];
        A_STATUS: w1c    = pwdata[NPINS-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (paddr[4:0])
      A_IN:     rdata[NPINS-1:0] = pin_v;
      A_EN:     rdata[NPINS-1:0] = en_q;
      A_TYPE:   rdata[NPINS-1:0] = type_q;
      A_POL:    rdata[NPINS-1:0] = pol_q;
      A_BOTH:   rdata[NPINS-1:0] = both_q;
      A_STATUS: rdata[NPINS-1:0] = status_q;
      default:  ;
    endcase
    prdata_d = (access && !pwrite) ? rdata : prdata_q;
    pready_d = access;
  end

  // A new event in the same cycle as its W1C keeps the bit set.
  always_comb begin
    rise      = pin_v & ~pin_q;
    fall      = ~pin_v & pin_q;
    edge_evt  = (both_q & (rise | fall)) | (~both_q & ((pol_q & rise) | (~pol_q & fall)));
    level_evt = (pol_q & pin_v) | (~pol_q & ~pin_v);
    evt       = armed ? (en_q & ((type_q & edge_evt) | (~type_q & level_evt))) : '0;
    status_d  = (status_q & ~w1c) | evt;
    irq_d     = |(status_q & en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      pin_q     <= '0;
      arm_cnt_q <= '0;
      en_q      <= '0;
      type_q    <= '0;
      pol_q     <= '0;
      both_q    <= '0;
      status_q  <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      pin_q     <= pin_d;
      arm_cnt_q <= arm_cnt_d;
      en_q      <= en_d;
      type_q    <= type_d;
      pol_q     <= pol_d;
      both_q    <= both_d;
      status_q  <= status_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      irq_q     <= irq_d;
    end
  end

  assign prdata = prdata_q;
  assign pready = pready_q;
  assign irq    = irq_q;

endmodule
